reg_writeback: RTL

REG_WRITEBACK -- requirements
Module: reg_writeback

---
 rtl/reg_writeback_if.sv | 41 ++++
 rtl/reg_writeback.sv | 103 ++++++++++
 2 files changed

// File: rtl/reg_writeback_if.sv
// Bundle of the writeback queue's producer, register-file, hazard and status signals.
// The slave modport is the queue itself; master is whoever drives the producers.
interface reg_writeback_if;
  logic        mem_valid;
  logic        mem_ready;
  logic [3:0]  mem_addr;
  logic [15:0] mem_data;
  logic        alu_valid;
  logic        alu_ready;
  logic [3:0]  alu_addr;
  logic [15:0] alu_data;
  logic [7:0]  bank_select;
  logic [3:0]  rf_write_addr;
  logic [15:0] rf_write_data;
  logic [7:0]  rf_bank_select;
  logic        rf_write_en;
  logic [3:0]  query_addr1;
  logic [3:0]  query_addr2;
  logic        hazard1;
  logic        hazard2;
  logic        empty;
  logic        ro_drop;

  modport slave (
    input  mem_valid, mem_addr, mem_data,
    input  alu_valid, alu_addr, alu_data,
    input  bank_select, query_addr1, query_addr2,
    output mem_ready, alu_ready,
    output rf_write_addr, rf_write_data, rf_bank_select, rf_write_en,
    output hazard1, hazard2, empty, ro_drop
  );

  modport master (
    output mem_valid, mem_addr, mem_data,
    output alu_valid, alu_addr, alu_data,
    output bank_select, query_addr1, query_addr2,
    input  mem_ready, alu_ready,
    input  rf_write_addr, rf_write_data, rf_bank_select, rf_write_en,
    input  hazard1, hazard2, empty, ro_drop
  );
endinterface

// File: rtl/reg_writeback.sv
// Two-producer register writeback queue: mem entries win ordering over ALU entries,
// drained one per cycle into a registered register-file write port with hazard lookup.
module reg_writeback #(
  parameter int DEPTH = 4
) (
  input  logic           clock,
  input  logic           reset_n,
  reg_writeback_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [3:0] RO_BASE = 4'hD;
  localparam logic [3:0] GLOBAL_BASE = 4'h8;

  typedef struct packed {
    logic [3:0]  addr;
    logic [15:0] data;
    logic [7:0]  bank;
  } entry_t;

  entry_t          fifo_q [DEPTH];
  entry_t          out_q;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic            rf_write_en_q;
  logic            ro_drop_q;

  logic mem_fire, alu_fire, mem_ro, alu_ro, mem_push, alu_push, pop;
  logic hazard1_c, hazard2_c;

  // Readiness looks only at the registered count, never at this cycle's pop.
  assign bus.mem_ready = (count_q <= CW'(DEPTH - 1));
  assign bus.alu_ready = bus.mem_valid ? (count_q <= CW'(DEPTH - 2))
                                       : (count_q <= CW'(DEPTH - 1));

  assign mem_fire = bus.mem_valid & bus.mem_ready;
  assign alu_fire = bus.alu_valid & bus.alu_ready;
  assign mem_ro   = (bus.mem_addr >= RO_BASE);
  assign alu_ro   = (bus.alu_addr >= RO_BASE);
  assign mem_push = mem_fire & ~mem_ro;
  assign alu_push = alu_fire & ~alu_ro;
  assign pop      = (count_q != '0);

  assign count_d  = count_q + CW'(mem_push) + CW'(alu_push) - CW'(pop);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      rf_write_en_q <= 1'b1;
      out_q         <= '0;
      ro_drop_q     <= 1'b0;
    end else begin
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_q + PW'(mem_push) + PW'(alu_push);
      rd_ptr_q      <= rd_ptr_q + PW'(pop);
      rf_write_en_q <= ~pop;
      if (pop) out_q <= fifo_q[rd_ptr_q];
      ro_drop_q     <= (mem_fire & mem_ro) | (alu_fire & alu_ro);
    end
  end

  // NOTE: queue storage is not reset; count and pointers alone decide which slots are live.
  always_ff @(posedge clock) begin
    if (mem_push) fifo_q[wr_ptr_q] <= '{addr: bus.mem_addr, data: bus.mem_data, bank: bus.bank_select};
    if (alu_push) fifo_q[wr_ptr_q + PW'(mem_push)] <= '{addr: bus.alu_addr, data: bus.alu_data,
                                                         bank: bus.bank_select};
  end

  function automatic logic hit(entry_t e, logic [3:0] q, logic [7:0] bank);
    return (e.addr == q) && ((e.addr >= GLOBAL_BASE) || (e.bank == bank));
  endfunction

  // NOTE: combinational outputs get a default first so no path leaves them holding (no latch).
  always_comb begin
    logic [PW-1:0] off;
    hazard1_c = 1'b0;
    hazard2_c = 1'b0;
    off       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rd_ptr_q;
      if ({1'b0, off} < count_q) begin
        if (hit(fifo_q[i], bus.query_addr1, bus.bank_select)) hazard1_c = 1'b1;
        if (hit(fifo_q[i], bus.query_addr2, bus.bank_select)) hazard2_c = 1'b1;
      end
    end
    if (!rf_write_en_q) begin
      if (hit(out_q, bus.query_addr1, bus.bank_select)) hazard1_c = 1'b1;
      if (hit(out_q, bus.query_addr2, bus.bank_select)) hazard2_c = 1'b1;
    end
  end

  assign bus.hazard1        = hazard1_c & (bus.query_addr1 < RO_BASE);
  assign bus.hazard2        = hazard2_c & (bus.query_addr2 < RO_BASE);
  assign bus.rf_write_en    = rf_write_en_q;
  assign bus.rf_write_addr  = out_q.addr;
  assign bus.rf_write_data  = out_q.data;
  assign bus.rf_bank_select = out_q.bank;
  assign bus.ro_drop        = ro_drop_q;
  assign bus.empty          = (count_q == '0) & rf_write_en_q;
endmodule
